// File: rtl/cla_adder_pipe_if.sv
// ---------------------------------------------------------------------------
// cla_adder_pipe_if
// Bundles the operand (upstream) and result (downstream) valid/ready channels
// of the pipelined CLA adder/subtractor into one interface.
//
//   in_valid   producer -> adder   operand beat valid
//   in_ready   adder -> producer   adder accepts operand beat this cycle
//   x, y       producer -> adder   operands A and B (N_BIT each)
//   cin        producer -> adder   carry-in, only meaningful when sub=0
//   sub        producer -> adder   0: x+y+cin, 1: x-y
//   out_valid  adder -> consumer   result beat valid
//   out_ready  consumer -> adder   consumer accepts result
//   sum        adder -> consumer   N_BIT result
//   cout       adder -> consumer   carry out of MSB (no-borrow when sub=1)
//   ovf        adder -> consumer   signed overflow
//
// master : the environment around the adder (drives operands, takes results)
// slave  : the adder itself
// ---------------------------------------------------------------------------
interface cla_adder_pipe_if #(
    parameter int N_BIT = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [N_BIT-1:0] x;
    logic [N_BIT-1:0] y;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [N_BIT-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, x, y, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, x, y, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_adder_pipe.sv
// ---------------------------------------------------------------------------
// cla_adder_pipe
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// The N_BIT operation is cut into STAGES slices of SLICE = N_BIT/STAGES bits.
// Stage k adds slice k with a SLICE-bit CLA and registers its carry, the sum
// bits produced so far and the still-unused upper operand bits. An accepted
// beat emerges STAGES cycles later; one beat per cycle is sustained while
// the consumer is ready.
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous, active-high reset; clears every stage and the
//         outputs, and holds in_ready low while asserted
//   bus   cla_adder_pipe_if.slave (operand and result channels)
//
// Parameters
//   N_BIT   operand/result width, must be a multiple of STAGES
//   STAGES  pipeline depth (1..N_BIT)
// ---------------------------------------------------------------------------
module cla_adder_pipe #(
    parameter int N_BIT  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    cla_adder_pipe_if.slave  bus
);
    localparam int SLICE = N_BIT / STAGES;

    // Parameter sanity: uneven slices would silently drop or overlap bits.
    if (STAGES < 1 || STAGES > N_BIT || (N_BIT % STAGES) != 0) begin : g_bad_params
        $error("cla_adder_pipe: N_BIT (%0d) must be a multiple of STAGES (%0d)", N_BIT, STAGES);
    end

    logic [STAGES-1:0] stageValid;
    logic [STAGES-1:0] en;
    logic              enChain;

    // Load-enable chain, walked from the output back to the input: a stage
    // may load when it is empty or when the stage after it is moving. This
    // lets bubbles collapse while a stalled consumer freezes the full tail.
    always_comb begin
        en      = '0;
        enChain = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            enChain = ~stageValid[k] | enChain;
            en[k]   = enChain;
        end
    end

    // Reset beats are discarded, so nothing may be accepted while rst is high.
    assign bus.in_ready = en[0] & ~rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be consumed when entering this stage, and the
        // number of sum bits known once this stage has done its slice.
        localparam int OPW  = N_BIT - k * SLICE;
        localparam int SUMW = (k + 1) * SLICE;

        logic [OPW-1:0]   opA;
        logic [OPW-1:0]   opB;
        logic             cIn;
        logic             vIn;
        logic [SLICE-1:0] gen;
        logic [SLICE-1:0] prop;
        logic [SLICE:0]   carry;
        logic [SLICE-1:0] sliceSum;
        logic             sliceCout;
        logic [SUMW-1:0]  sumD;
        logic [SUMW-1:0]  sumQ;
        logic             carryQ;
        logic             validQ;

        // Stage 0 takes operands straight from the bus; B is inverted here
        // for subtraction so every later stage only ever adds.
        if (k == 0) begin : g_src
            assign opA  = bus.x;
            assign opB  = bus.y ^ {N_BIT{bus.sub}};
            assign cIn  = bus.sub | bus.cin;
            assign vIn  = bus.in_valid;
            assign sumD = sliceSum;
        end else begin : g_src
            assign opA  = g_stage[k-1].g_ops.aQ;
            assign opB  = g_stage[k-1].g_ops.bQ;
            assign cIn  = g_stage[k-1].carryQ;
            assign vIn  = g_stage[k-1].validQ;
            assign sumD = {sliceSum, g_stage[k-1].sumQ};
        end

        assign gen  = opA[SLICE-1:0] & opB[SLICE-1:0];
        assign prop = opA[SLICE-1:0] ^ opB[SLICE-1:0];

        // Slice carry network from generate/propagate terms. Each carry is a
        // pure function of G, P and the slice carry-in, so synthesis flattens
        // the loop into two-level lookahead logic.
        always_comb begin
            carry    = '0;
            carry[0] = cIn;
            for (int i = 0; i < SLICE; i++) begin
                carry[i+1] = gen[i] | (prop[i] & carry[i]);
            end
            sliceSum  = prop ^ carry[SLICE-1:0];
            sliceCout = carry[SLICE];
        end

        // Stage control/data register: advances only when en[k], otherwise
        // holds so a stalled beat is never lost or duplicated.
        always_ff @(posedge clk) begin
            if (rst) begin
                validQ <= 1'b0;
                sumQ   <= '0;
                carryQ <= 1'b0;
            end else if (en[k]) begin
                validQ <= vIn;
                sumQ   <= sumD;
                carryQ <= sliceCout;
            end
        end

        assign stageValid[k] = validQ;

        // Upper operand bits ride along untouched for the later slices. They
        // carry no control meaning, so they are not cleared by reset.
        if (k < STAGES - 1) begin : g_ops
            logic [OPW-SLICE-1:0] aQ;
            logic [OPW-SLICE-1:0] bQ;

            always_ff @(posedge clk) begin
                if (en[k]) begin
                    aQ <= opA[OPW-1:SLICE];
                    bQ <= opB[OPW-1:SLICE];
                end
            end
        end

        // Signed overflow needs the operand MSBs, which only the top slice
        // still sees, so the flag is formed and registered here.
        if (k == STAGES - 1) begin : g_last
            logic ovfQ;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovfQ <= 1'b0;
                end else if (en[k]) begin
                    ovfQ <= (opA[OPW-1] == opB[OPW-1]) & (sliceSum[SLICE-1] != opA[OPW-1]);
                end
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].validQ;
    assign bus.sum       = g_stage[STAGES-1].sumQ;
    assign bus.cout      = g_stage[STAGES-1].carryQ;
    assign bus.ovf       = g_stage[STAGES-1].g_last.ovfQ;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// ---------------------------------------------------------------------------
// tb_cla_adder_pipe
// Self-checking bench for cla_adder_pipe (N_BIT=32, STAGES=4). Inputs are
// driven on the falling edge and outputs sampled 1 time unit later, so the
// rising edge always sees settled values.
// ---------------------------------------------------------------------------
module tb_cla_adder_pipe;
    localparam int N_BIT  = 32;
    localparam int STAGES = 4;
    localparam int BEATS  = 2000;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;

    cla_adder_pipe_if #(.N_BIT(N_BIT)) bus ();

    cla_adder_pipe #(
        .N_BIT  (N_BIT),
        .STAGES (STAGES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: signed/unsigned integer arithmetic, returns {ovf, cout, sum}.
    function automatic logic [33:0] refModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic c, input logic s);
        longint    sa;
        longint    sb;
        longint    r;
        logic [32:0] u;
        logic      co;
        logic      ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            r  = sa - sb;
            co = (a >= b);
        end else begin
            r  = sa + sb + longint'(c);
            u  = {1'b0, a} + {1'b0, b} + {32'd0, c};
            co = u[32];
        end
        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return {ov, co, r[31:0]};
    endfunction

    task automatic idleInputs();
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    // Sends one beat into an empty pipe and waits (bounded) for its result.
    task automatic runBeat(input logic [31:0] a, input logic [31:0] b, input logic c,
                           input logic s, output int lat, output logic acc,
                           output logic [31:0] sumOut, output logic coutOut,
                           output logic ovfOut);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x        = a;
        bus.y        = b;
        bus.cin      = c;
        bus.sub      = s;
        #1 acc = bus.in_ready;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        #1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        sumOut  = bus.sum;
        coutOut = bus.cout;
        ovfOut  = bus.ovf;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idleInputs();
        repeat (3) @(negedge clk);
        #1;
        testsRun++;
        if (bus.in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        testsRun++;
        if (bus.out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        testsRun++;
        if (bus.sum !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_sum: got %h expected 0", bus.sum); end
        testsRun++;
        if ({bus.cout, bus.ovf} !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_flags: got %b%b expected 00", bus.cout, bus.ovf); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        testsRun++;
        if (bus.in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_release_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_add_wrap();
        int lat; logic acc; logic [31:0] s; logic co; logic ov;
        runBeat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, acc, s, co, ov);
        testsRun++;
        if (acc !== 1'b1) begin testsFailed++; $display("[TB] FAIL wrap_accept: got %b expected 1", acc); end
        testsRun++;
        if (lat != STAGES) begin testsFailed++; $display("[TB] FAIL wrap_latency: got %0d expected %0d", lat, STAGES); end
        testsRun++;
        if ({ov, co, s} !== {1'b0, 1'b1, 32'h0000_0000}) begin
            testsFailed++; $display("[TB] FAIL wrap_result: got ovf=%b cout=%b sum=%h expected ovf=0 cout=1 sum=00000000", ov, co, s);
        end
    endtask

    task automatic test_carry_chain();
        int lat; logic acc; logic [31:0] s; logic co; logic ov;
        runBeat(32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, lat, acc, s, co, ov);
        testsRun++;
        if (lat != STAGES) begin testsFailed++; $display("[TB] FAIL chain_latency: got %0d expected %0d", lat, STAGES); end
        testsRun++;
        if ({ov, co, s} !== {1'b0, 1'b0, 32'h0100_0000}) begin
            testsFailed++; $display("[TB] FAIL chain_result: got ovf=%b cout=%b sum=%h expected ovf=0 cout=0 sum=01000000", ov, co, s);
        end
    endtask

    task automatic test_overflow_sub();
        logic [31:0] ax [5] = '{32'h7FFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h0000_000A, 32'h1234_5678};
        logic [31:0] by [5] = '{32'h0000_0001, 32'h0000_0007, 32'h0000_0001, 32'h0000_0003, 32'h1234_5678};
        logic        cv [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        sv [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [33:0] ex [5] = '{{2'b10, 32'h8000_0000}, {2'b00, 32'hFFFF_FFFE},
                                {2'b11, 32'h7FFF_FFFF}, {2'b01, 32'h0000_0007},
                                {2'b01, 32'h0000_0000}};
        int lat; logic acc; logic [31:0] s; logic co; logic ov;
        for (int i = 0; i < 5; i++) begin
            runBeat(ax[i], by[i], cv[i], sv[i], lat, acc, s, co, ov);
            testsRun++;
            if ({ov, co, s} !== ex[i]) begin
                testsFailed++;
                $display("[TB] FAIL ovf_sub_vec%0d: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                         i, ov, co, s, ex[i][33], ex[i][32], ex[i][31:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          sent = 0;
        int          rcvd = 0;
        int          cyc  = 0;
        logic        holding = 1'b0;
        logic        sawStall = 1'b0;
        logic [31:0] heldSum = '0;
        logic [31:0] expSum;
        while (rcvd < 10 && cyc < 80) begin
            @(negedge clk);
            bus.out_ready = !(cyc >= 2 && cyc < 8);
            bus.in_valid  = (sent < 10);
            bus.x         = 32'(sent);
            bus.y         = 32'(sent);
            bus.cin       = 1'b0;
            bus.sub       = 1'b0;
            #1;
            if (holding) begin
                testsRun++;
                if (bus.out_valid !== 1'b1 || bus.sum !== heldSum) begin
                    testsFailed++; $display("[TB] FAIL b2b_hold_stable: got valid=%b sum=%h expected valid=1 sum=%h", bus.out_valid, bus.sum, heldSum);
                end
            end
            if (bus.in_valid && !bus.in_ready) sawStall = 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                expSum = 32'(2 * rcvd);
                testsRun++;
                if (bus.sum !== expSum) begin
                    testsFailed++; $display("[TB] FAIL b2b_result%0d: got %h expected %h", rcvd, bus.sum, expSum);
                end
                rcvd++;
            end
            holding = bus.out_valid && !bus.out_ready;
            heldSum = bus.sum;
            if (bus.in_valid && bus.in_ready) sent++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        testsRun++;
        if (rcvd != 10) begin testsFailed++; $display("[TB] FAIL b2b_count: got %0d results expected 10", rcvd); end
        testsRun++;
        if (sawStall !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_backpressure: in_ready never dropped, got %b expected 1", sawStall); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            testsRun++;
            if (bus.out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_no_extra: got out_valid=%b sum=%h expected out_valid=0", bus.out_valid, bus.sum); end
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.x        = 32'(100 + i);
            bus.y        = 32'(i);
            bus.cin      = 1'b0;
            bus.sub      = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        #1;
        testsRun++;
        if (bus.in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_in_ready_low: got %b expected 0", bus.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        testsRun++;
        if (bus.out_valid !== 1'b0 || bus.sum !== 32'h0 || bus.cout !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL midrst_cleared: got valid=%b sum=%h cout=%b expected 0/0/0", bus.out_valid, bus.sum, bus.cout);
        end
        testsRun++;
        if (bus.in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_in_ready: got %b expected 1", bus.in_ready); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            testsRun++;
            if (bus.out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_stale: got out_valid=%b sum=%h expected 0", bus.out_valid, bus.sum); end
        end
    endtask

    task automatic test_random();
        logic [33:0] sb[$];
        logic [33:0] exp;
        int          sent = 0;
        int          rcvd = 0;
        int          cyc  = 0;
        while (rcvd < BEATS && cyc < 20000) begin
            @(negedge clk);
            bus.in_valid  = (sent < BEATS) && ($urandom_range(0, 3) != 0);
            bus.x         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            bus.y         = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            bus.cin       = 1'($urandom_range(0, 1));
            bus.sub       = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                testsRun++;
                if (sb.size() == 0) begin
                    testsFailed++; $display("[TB] FAIL rand_unexpected: got sum=%h with no beat outstanding, expected none", bus.sum);
                end else begin
                    exp = sb.pop_front();
                    if ({bus.ovf, bus.cout, bus.sum} !== exp) begin
                        testsFailed++;
                        $display("[TB] FAIL rand_beat%0d: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                                 rcvd, bus.ovf, bus.cout, bus.sum, exp[33], exp[32], exp[31:0]);
                    end
                end
                rcvd++;
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(refModel(bus.x, bus.y, bus.cin, bus.sub));
                sent++;
            end
            cyc++;
        end
        idleInputs();
        testsRun++;
        if (rcvd != BEATS) begin testsFailed++; $display("[TB] FAIL rand_count: got %0d results expected %0d", rcvd, BEATS); end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        idleInputs();
        test_reset();
        test_add_wrap();
        test_carry_chain();
        test_overflow_sub();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
